// File: rtl/audio_ram_arbiter.sv
// rtl/audio_ram_arbiter.sv - sample RAM port arbiter between SD loader writes and playback reads
module audio_ram_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int MAX_WR_BURST = 8,
  parameter int RD_TIMEOUT   = 1024
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_op_begun,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int STREAK_W = $clog2(MAX_WR_BURST + 1);
  localparam int TMO_W    = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;

  state_t              state;
  logic [STREAK_W-1:0] wr_streak;
  logic [TMO_W-1:0]    rd_timer;
  logic                rd_eligible;
  logic                grant_rd;
  logic                grant_wr;
  logic                streak_full;

  // Reads are only eligible once the loader has finished initialising the RAM.
  assign rd_eligible = rd_req & init_done;
  assign streak_full = (wr_streak >= STREAK_W'(MAX_WR_BURST));
  // A pending read wins once the write burst budget is used up, so playback never starves.
  assign grant_rd    = rd_eligible & (~wr_req | streak_full);
  assign grant_wr    = wr_req & ~grant_rd;

  // Acks track the controller's acceptance in the same cycle it happens.
  assign wr_ack = (state == WR_ISSUE) & mem_op_begun;
  assign rd_ack = (state == RD_ISSUE) & mem_op_begun;

  // Arbitration FSM; every mem_* command output and read result is registered here.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state      <= IDLE;
      wr_streak  <= '0;
      rd_timer   <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The streak only means something while a read is actually waiting.
          if (!rd_eligible) wr_streak <= '0;
          if (grant_rd) begin
            mem_addr  <= rd_addr;
            mem_we    <= 1'b0;
            mem_req   <= 1'b1;
            wr_streak <= '0;
            state     <= RD_ISSUE;
          end else if (grant_wr) begin
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            mem_we    <= 1'b1;
            mem_req   <= 1'b1;
            if (rd_eligible && !streak_full) wr_streak <= wr_streak + 1'b1;
            state     <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (mem_op_begun) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_ISSUE: begin
          if (mem_op_begun) begin
            mem_req  <= 1'b0;
            rd_timer <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            rd_data  <= mem_rdata;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else if (rd_timer == TMO_W'(RD_TIMEOUT - 1)) begin
            // Give the fetcher silence rather than stale data, and remember it happened.
            rd_data    <= '0;
            rd_valid   <= 1'b1;
            rd_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            rd_timer <= rd_timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_ram_arbiter.sv
// tb/tb_audio_ram_arbiter.sv - directed self-checking bench for audio_ram_arbiter
module tb_audio_ram_arbiter;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        init_done;
  logic        wr_req;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_timeout;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_op_begun;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  audio_ram_arbiter #(
    .ADDR_W(25), .DATA_W(16), .MAX_WR_BURST(8), .RD_TIMEOUT(1024)
  ) dut (
    .clk50(clk50), .reset(reset), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_timeout(rd_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_op_begun(mem_op_begun), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #10 clk50 = ~clk50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(negedge clk50);
    #1;
  endtask

  int hits;
  int grants;
  int cycles;
  int n;
  int pulses;
  logic done;

  initial begin
    reset = 1'b1; init_done = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    mem_op_begun = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) tick();
    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_mem_we", 32'(mem_we), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 0);
    check_eq("rst_wr_ack", 32'(wr_ack), 0);
    check_eq("rst_rd_ack", 32'(rd_ack), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_rd_timeout", 32'(rd_timeout), 0);
    reset = 1'b0;
    tick();

    // single write, controller accepts 3 cycles after mem_req
    wr_req = 1'b1; wr_addr = 25'h000010; wr_data = 16'hBEEF;
    tick();
    check_eq("wr_mem_req", 32'(mem_req), 1);
    check_eq("wr_mem_we", 32'(mem_we), 1);
    check_eq("wr_mem_addr", 32'(mem_addr), 32'h10);
    check_eq("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    check_eq("wr_ack_early0", 32'(wr_ack), 0);
    tick();
    check_eq("wr_ack_early1", 32'(wr_ack), 0);
    tick();
    check_eq("wr_ack_early2", 32'(wr_ack), 0);
    tick();
    mem_op_begun = 1'b1; #1;
    check_eq("wr_ack_pulse", 32'(wr_ack), 1);
    check_eq("wr_no_rd_ack", 32'(rd_ack), 0);
    tick();
    mem_op_begun = 1'b0; wr_req = 1'b0; #1;
    check_eq("wr_ack_after", 32'(wr_ack), 0);
    check_eq("wr_mem_req_drop", 32'(mem_req), 0);

    // read blocked until init_done
    rd_req = 1'b1; rd_addr = 25'h001234; hits = 0;
    repeat (100) begin
      tick();
      if (mem_req) hits++;
    end
    check_eq("rd_blocked", 32'(hits), 0);
    init_done = 1'b1;
    tick();
    check_eq("rd_mem_req", 32'(mem_req), 1);
    check_eq("rd_mem_we", 32'(mem_we), 0);
    check_eq("rd_mem_addr", 32'(mem_addr), 32'h1234);
    mem_op_begun = 1'b1; #1;
    check_eq("rd_ack_pulse", 32'(rd_ack), 1);
    check_eq("rd_no_wr_ack", 32'(wr_ack), 0);
    tick();
    mem_op_begun = 1'b0; rd_req = 1'b0; #1;
    check_eq("rd_ack_after", 32'(rd_ack), 0);
    check_eq("rd_wait_mem_req", 32'(mem_req), 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hA5A5; #1;
    check_eq("rd_valid_early", 32'(rd_valid), 0);
    tick();
    mem_rvalid = 1'b0; #1;
    check_eq("rd_valid_pulse", 32'(rd_valid), 1);
    check_eq("rd_data_a5a5", 32'(rd_data), 32'hA5A5);
    tick();
    check_eq("rd_valid_end", 32'(rd_valid), 0);
    check_eq("rd_data_hold", 32'(rd_data), 32'hA5A5);

    // both requesters saturated: 8 writes then 1 read, repeating
    wr_req = 1'b1; rd_req = 1'b1; mem_op_begun = 1'b1; mem_rvalid = 1'b1;
    wr_addr = 25'h000100; rd_addr = 25'h000200;
    grants = 0; cycles = 0;
    while (grants < 27 && cycles < 300) begin
      tick();
      cycles++;
      if (wr_ack || rd_ack) begin
        check_eq("grant_exclusive", 32'(wr_ack & rd_ack), 0);
        check_eq($sformatf("grant%0d_is_rd", grants), 32'(rd_ack), 32'((grants % 9) == 8));
        grants++;
      end
    end
    check_eq("burst_grants", 32'(grants), 27);
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) tick();
    mem_op_begun = 1'b0; mem_rvalid = 1'b0;
    tick();

    // read that never returns data
    rd_req = 1'b1; rd_addr = 25'h002000; mem_op_begun = 1'b1;
    done = 1'b0; cycles = 0;
    while (!done && cycles < 10) begin
      tick();
      cycles++;
      done = rd_ack;
    end
    check_eq("tmo_rd_ack", 32'(done), 1);
    n = 0; done = 1'b0;
    while (!done && n < 1100) begin
      tick();
      n++;
      if (n == 1) begin
        mem_op_begun = 1'b0; rd_req = 1'b0;
      end
      done = rd_valid;
    end
    check_eq("tmo_latency", 32'(n), 1025);
    check_eq("tmo_rd_data", 32'(rd_data), 0);
    check_eq("tmo_sticky_set", 32'(rd_timeout), 1);

    // normal read afterwards keeps the sticky flag
    tick();
    rd_req = 1'b1; rd_addr = 25'h000042;
    tick();
    check_eq("post_tmo_mem_req", 32'(mem_req), 1);
    mem_op_begun = 1'b1; #1;
    check_eq("post_tmo_rd_ack", 32'(rd_ack), 1);
    tick();
    mem_op_begun = 1'b0; rd_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_rvalid = 1'b0; #1;
    check_eq("post_tmo_rd_valid", 32'(rd_valid), 1);
    check_eq("post_tmo_rd_data", 32'(rd_data), 32'h1111);
    check_eq("tmo_sticky_hold", 32'(rd_timeout), 1);

    // reset while waiting for read data; the late data must be ignored
    tick();
    rd_req = 1'b1; rd_addr = 25'h000777;
    tick();
    mem_op_begun = 1'b1; #1;
    check_eq("rst_rd_issue_ack", 32'(rd_ack), 1);
    tick();
    mem_op_begun = 1'b0; rd_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
    pulses = 0;
    repeat (6) begin
      tick();
      mem_rvalid = 1'b0;
      if (rd_valid) pulses++;
    end
    check_eq("rstw_no_rd_valid", 32'(pulses), 0);
    check_eq("rstw_mem_req", 32'(mem_req), 0);
    check_eq("rstw_mem_addr", 32'(mem_addr), 0);
    check_eq("rstw_rd_data", 32'(rd_data), 0);
    check_eq("rstw_rd_timeout", 32'(rd_timeout), 0);
    check_eq("rstw_acks", 32'({wr_ack, rd_ack}), 0);
    wr_req = 1'b1; wr_addr = 25'h000055; wr_data = 16'h1234;
    tick();
    check_eq("rstw_idle_grant", 32'({mem_req, mem_we}), 32'h3);
    check_eq("rstw_idle_addr", 32'(mem_addr), 32'h55);
    wr_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
